// File: rtl/result_drain_ctrl.sv
// Drains the result BRAM as a framed byte stream: header, 16-bit word count,
// payload words LSB-first, then a mod-256 checksum over count and payload bytes.
module result_drain_ctrl #(
    parameter int          ADDR_W   = 10,
    parameter int          DATA_W   = 32,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   cfg_word_count,
    output logic              bram_rd_en,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic [DATA_W-1:0] bram_rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done_pulse,
    output logic [ADDR_W:0]   words_sent
);

    localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_RD, S_WAIT, S_SEND, S_CSUM, S_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W:0]     words_sent_q;
    logic [1:0]          idx_q;
    logic [DATA_W-1:0]   shift_q;
    logic [7:0]          csum_q;
    logic [7:0]          tx_data_q;
    logic                tx_valid_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                busy_q;
    logic                done_q;

    logic [ADDR_W:0]     cnt_clamp_d;
    logic [15:0]         cnt16_d;
    logic [7:0]          csum_d;
    logic [ADDR_W:0]     words_d;
    logic                hs;

    assign cnt_clamp_d = (cfg_word_count > MAX_CNT) ? MAX_CNT : cfg_word_count;
    assign cnt16_d     = 16'(cnt_q);
    // Running sum including the byte currently being handed off.
    assign csum_d      = csum_q + tx_data_q;
    assign words_d     = words_sent_q + 1'b1;
    assign hs          = tx_valid_q && tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            words_sent_q <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            csum_q       <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (abort && state_q != S_IDLE) begin
            state_q    <= S_IDLE;
            tx_valid_q <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        cnt_q        <= cnt_clamp_d;
                        words_sent_q <= '0;
                        csum_q       <= '0;
                        rd_addr_q    <= '0;
                        idx_q        <= '0;
                        tx_data_q    <= HDR_BYTE;
                        tx_valid_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (hs) begin
                        idx_q <= idx_q + 1'b1;
                        case (idx_q)
                            2'd0: tx_data_q <= cnt16_d[7:0];
                            2'd1: begin
                                csum_q    <= csum_d;
                                tx_data_q <= cnt16_d[15:8];
                            end
                            default: begin
                                csum_q <= csum_d;
                                if (cnt_q != '0) begin
                                    tx_valid_q <= 1'b0;
                                    rd_en_q    <= 1'b1;
                                    rd_addr_q  <= words_sent_q[ADDR_W-1:0];
                                    state_q    <= S_RD;
                                end else begin
                                    tx_data_q <= csum_d;
                                    state_q   <= S_CSUM;
                                end
                            end
                        endcase
                    end
                end
                S_RD: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    shift_q    <= bram_rd_data;
                    tx_data_q  <= bram_rd_data[7:0];
                    tx_valid_q <= 1'b1;
                    idx_q      <= '0;
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    if (hs) begin
                        csum_q <= csum_d;
                        idx_q  <= idx_q + 1'b1;
                        if (idx_q == 2'd3) begin
                            words_sent_q <= words_d;
                            if (words_d < cnt_q) begin
                                tx_valid_q <= 1'b0;
                                rd_en_q    <= 1'b1;
                                rd_addr_q  <= words_d[ADDR_W-1:0];
                                state_q    <= S_RD;
                            end else begin
                                tx_data_q <= csum_d;
                                state_q   <= S_CSUM;
                            end
                        end else begin
                            tx_data_q <= shift_q[15:8];
                            shift_q   <= shift_q >> 8;
                        end
                    end
                end
                S_CSUM: begin
                    if (hs) begin
                        tx_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bram_rd_en   = rd_en_q;
    assign bram_rd_addr = rd_addr_q;
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign busy         = busy_q;
    assign done_pulse   = done_q;
    assign words_sent   = words_sent_q;

endmodule

// File: doc/result_drain_ctrl.md
# result_drain_ctrl

Sequences readout of the 1K×32 output BRAM written by the sparse systolic array and streams it as a framed byte stream toward the UART TX path. On a start pulse it reads `cfg_word_count` words from address 0 upward and serializes each word LSB-first, wrapped in a header and checksum. It owns the BRAM read port and the TX byte handshake, replacing the RX→TX loopback with real result upload.

## Interface
- `ADDR_W`, 10, output BRAM address width; depth is 2^ADDR_W words.
- `DATA_W`, 32, BRAM word width; fixed at 4 bytes per word.
- `HDR_BYTE`, 8'hA5, frame start byte.

- `clk`  in  1  single clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `abort`  in  1  synchronous abort; returns to IDLE, no done_pulse.
- `cfg_word_count`  in  ADDR_W+1  words to send; sampled on accepted start.
- `bram_rd_en`  out  1  BRAM read strobe.
- `bram_rd_addr`  out  ADDR_W  BRAM read address.
- `bram_rd_data`  in  DATA_W  read data, valid exactly 1 cycle after `bram_rd_en`.
- `tx_data`  out  8  byte to UART TX.
- `tx_valid`  out  1  byte valid.
- `tx_ready`  in  1  TX accepts byte.
- `busy`  out  1  frame in progress.
- `done_pulse`  out  1  one-cycle frame completion.
- `words_sent`  out  ADDR_W+1  words fully transferred in current or last frame.

## Operation
- Frame: `HDR_BYTE`, count[7:0], count[15:8] (zero-extended), then per word bytes [7:0],[15:8],[23:16],[31:24], then CSUM.
- CSUM: mod-256 sum of the count bytes and all payload bytes; header and CSUM itself excluded.
- Count clamp: `cfg_word_count > 2^ADDR_W` is clamped to 2^ADDR_W. The clamped value is used in the count bytes.
- States:
  - IDLE: on `start`, latch count, clear csum/addr/`words_sent`, go to HDR.
  - HDR: sends 3 bytes; then RD if count>0, else CSUM.
  - RD: asserts `bram_rd_en` for one cycle with `bram_rd_addr`=addr; go to WAIT.
  - WAIT: capture `bram_rd_data` into 32-bit shift register; go to SEND.
  - SEND: sends 4 bytes. After the 4th handshake, addr and `words_sent` increment; go to RD if words remain, else CSUM.
  - CSUM: sends checksum byte; on handshake go to DONE.
  - DONE: `done_pulse`=1 for one cycle; go to IDLE.
- `start` outside IDLE is ignored.
- `abort` in any non-IDLE state has priority over all transitions:
  - Next state IDLE, `tx_valid` deasserted, no `done_pulse`.
  - `words_sent` holds its value.
- addr never wraps within a frame; clamping guarantees addr ≤ 2^ADDR_W−1 on every read.

## Timing
- Reset values: `bram_rd_en`=0, `bram_rd_addr`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `done_pulse`=0, `words_sent`=0; state IDLE.
- Reset asserted mid-frame aborts immediately (async); no partial byte is held.
- `start` at cycle T → `busy`=1 and `tx_valid`=1 with `tx_data`=`HDR_BYTE` at T+1.
- Byte transfer happens on `tx_valid && tx_ready` at a rising edge. The next byte is presented the following cycle, giving 1 byte/cycle inside header and word.
- While `tx_valid && !tx_ready`, `tx_data` is held stable; `tx_valid` never drops without a handshake except on abort or reset.
- `tx_valid`=0 in RD and WAIT, giving 2 idle cycles between words.
- `busy`=1 from T+1 through the DONE cycle inclusive; `done_pulse` is coincident with the last busy cycle.
- Minimum frame length at full `tx_ready`:
  - count=N>0: 3 + 6N + 1 + 1 cycles.
  - count=0: 5 cycles.

## Test plan
- Nominal: bram[0]=0x11223344, bram[1]=0xAABBCCDD, count=2, `tx_ready`=1 → bytes A5 02 00 44 33 22 11 DD CC BB AA BA; `done_pulse` once; `words_sent`=2; exactly 2 `bram_rd_en` pulses at addrs 0,1.
- Empty: count=0 → bytes A5 00 00 00; no `bram_rd_en`; `done_pulse` 5 cycles after start.
- Backpressure: same as nominal, with `tx_ready` low for 5 cycles while byte 0x33 is presented → `tx_data` stays 0x33 with `tx_valid`=1 throughout; final stream identical.
- Clamp: count=2047, bram[i]=i → count bytes 00 04; reads addrs 0..1023 exactly once; `words_sent`=1024; CSUM equals model sum.
- Abort/reset: abort during SEND of word 1 → `tx_valid`=0 next cycle, no `done_pulse`, `words_sent`=1, new start then works. Repeat with `rst_n` low mid-frame → all outputs at reset values immediately.
- Start while busy: second `start` pulse during HDR → ignored; single frame emitted, single `done_pulse`.
